sid_mdac_sched: RTL and testbench
=================================

// Module: sid_mdac_sched
// PURPOSE
//  Time-multiplexes one signed16 x unsigned8 multiplier across the three voice MDAC products and the master-volume stage.
//  Sits between the voice/envelope generators and the filter/mixer path, replacing three dedicated MAC16 tiles with one.
//  Each CLKen frame: snapshot operands, issue up to 4 multiplies back-to-back, then present all results together.
// PARAMETERS
//  MUL_LAT   2   pipeline depth of shared multiplier (issue -> product), >=1
//  NSLOT     4   multiply slots per frame (3 voices + volume); 3 when SID_VOLUME_EN undefined
// PORTS
//  CLK       in   1   master clock
//  RST       in   1   synchronous, active-high reset
//  CLKen     in   1   1 MHz frame strobe; starts a frame when IDLE
//  VOICE0-2  in   12  signed voice waveforms (two's complement)
//  ENV0-2    in   8   unsigned envelope levels
//  MIX_IN    in   16  signed post-filter mix to be volume-scaled
//  VOLUME    in   4   master volume (register 0x18 bits 3:0)
//  AMP0-2    out  16  signed voice amplitudes, registered
//  OUT       out  16  signed volume-scaled mix, registered
//  VALID     out  1   one-cycle pulse: AMP0-2/OUT updated this cycle
//  BUSY      out  1   high from frame start until the VALID cycle inclusive
//  OVERRUN   out  1   one-cycle pulse: CLKen arrived while BUSY, frame dropped
// BEHAVIOUR
//  Reset: state=IDLE, AMP0-2=0, OUT=0, VALID=0, BUSY=0, OVERRUN=0, pipeline tags cleared; RST beats any same-cycle CLKen.
//  FSM: IDLE -CLKen-> ISSUE (operands latched same edge) -slot NSLOT-1 issued-> DRAIN -last tag out-> DONE -> IDLE.
//  ISSUE: one slot per cycle, slot order 0,1,2,(3); slot tag travels with operands through multiplier pipeline.
//  Voice slot k: A={VOICEk,4'b0}, B=ENVk; AMPk <= product[23:8] (arithmetic, floor toward -inf).
//  Volume slot: A=MIX_IN, B={VOLUME,4'b0}; OUT <= product[23:8] = floor(MIX_IN*VOLUME/16); VOLUME=15 -> 15/16 gain.
//  Results land in shadow regs as tags emerge; AMP0-2/OUT copied atomically in DONE, VALID high that cycle only.
//  Latency CLKen -> VALID = NSLOT + MUL_LAT + 1 cycles (7 at defaults); CLKen period must exceed this.
//  CLKen while BUSY (incl. DONE cycle): OVERRUN pulses, frame ignored, in-flight frame unaffected.
//  CLKen in cycle after DONE (state IDLE): accepted normally.
//  Operand changes after the latch edge have no effect on current frame.
//  RST mid-frame: abort, pipeline flushed, no VALID, outputs return to 0.
//  Product width 24 bits; no saturation required (max |A*B| < 2^23 for both slot kinds).
// CONFIGURATION
//  SID_VOLUME_EN defined: NSLOT=4, volume slot scheduled, OUT = scaled MIX_IN.
//  SID_VOLUME_EN undefined: NSLOT=3, no volume slot, OUT registered copy of MIX_IN at DONE, VOLUME ignored; latency 6.
// STRUCTURE
//  sid_pkg: slot encoding (SLOT_V0..SLOT_V2, SLOT_VOL), MUL_A_W=16, MUL_B_W=8, MUL_P_W=24, state encoding.
//  Sub-module sid_shared_mul: signed16 x unsigned8, MUL_LAT stages, passes valid+slot tag alongside product;
//   maps to SB_MAC16 on iCE40, behavioural multiply otherwise.
//  Top: FSM, slot counter, operand snapshot regs, result shadow regs, output regs.
// TESTING
//  Reset: hold RST 3 cycles with CLKen pulsing -> all outputs 0, no VALID, no OVERRUN.
//  Frame: VOICE0=0x7FF/ENV0=255, VOICE1=0x800/ENV1=128, VOICE2=0/ENV2=255, MIX_IN=16000, VOLUME=8
//   -> VALID 7 cycles after CLKen; AMP0=32624, AMP1=-16384, AMP2=0, OUT=8000.
//  Volume: MIX_IN=-16000, VOLUME=15 -> OUT=-15000; VOLUME=0 -> OUT=0.
//  Overrun: second CLKen 3 cycles after first -> OVERRUN pulse, single VALID, results from first snapshot only.
//  Mid-frame reset: RST at cycle 2 of ISSUE -> no VALID, outputs 0; next CLKen yields correct frame.
//  Without SID_VOLUME_EN: same frame -> VALID after 6 cycles, OUT=16000.

Source files
------------

// File: rtl/sid_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sid_pkg : operand widths, slot tags and FSM encoding for sid_mdac_sched.
// Option macro: SID_VOLUME_EN (adds the master-volume multiply slot) | rev 1.0
// ---------------------------------------------------------------------------
package sid_pkg;

  localparam int MUL_A_W = 16;
  localparam int MUL_B_W = 8;
  localparam int MUL_P_W = 24;
  localparam int TAG_W   = 2;

  localparam logic [TAG_W-1:0] SLOT_V0  = 2'd0;
  localparam logic [TAG_W-1:0] SLOT_V1  = 2'd1;
  localparam logic [TAG_W-1:0] SLOT_V2  = 2'd2;
  localparam logic [TAG_W-1:0] SLOT_VOL = 2'd3;

`ifdef SID_VOLUME_EN
  localparam int SID_NSLOT = 4;
`else
  localparam int SID_NSLOT = 3;
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // 12-bit voice sample scaled up to the full signed 16-bit multiplier port.
  function automatic logic [MUL_A_W-1:0] voice_to_a(input logic [11:0] v);
    return {v, 4'b0000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sid_shared_mul.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sid_shared_mul : signed16 x unsigned8 multiplier, MUL_LAT register stages,
// valid and slot tag carried alongside the product.                | rev 1.0
// ---------------------------------------------------------------------------
module sid_shared_mul
  import sid_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic [TAG_W-1:0]   i_tag,
  input  logic [MUL_A_W-1:0] i_a,
  input  logic [MUL_B_W-1:0] i_b,
  output logic               o_valid,
  output logic [TAG_W-1:0]   o_tag,
  output logic [MUL_P_W-1:0] o_prod
);

  localparam int EXT_W = MUL_P_W + 1;

  logic [EXT_W-1:0] w_a_ext;
  logic [EXT_W-1:0] w_b_ext;
  logic [EXT_W-1:0] w_full;
  logic             w_unused_msb;

  // Low EXT_W bits of an unsigned multiply equal the signed result once A is
  // sign-extended and B zero-extended to the full width.
  assign w_a_ext      = {{(EXT_W-MUL_A_W){i_a[MUL_A_W-1]}}, i_a};
  assign w_b_ext      = {{(EXT_W-MUL_B_W){1'b0}}, i_b};
  assign w_full       = w_a_ext * w_b_ext;
  assign w_unused_msb = w_full[EXT_W-1];

  logic [MUL_LAT-1:0] r_vld;
  logic [TAG_W-1:0]   r_tag  [MUL_LAT];
  logic [MUL_P_W-1:0] r_prod [MUL_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < MUL_LAT; s++) begin
        r_vld[s]  <= 1'b0;
        r_tag[s]  <= '0;
        r_prod[s] <= '0;
      end
    end else begin
      r_vld[0]  <= i_valid;
      r_tag[0]  <= i_tag;
      r_prod[0] <= w_full[MUL_P_W-1:0];
      for (int s = 1; s < MUL_LAT; s++) begin
        r_vld[s]  <= r_vld[s-1];
        r_tag[s]  <= r_tag[s-1];
        r_prod[s] <= r_prod[s-1];
      end
    end
  end

  assign o_valid = r_vld[MUL_LAT-1];
  assign o_tag   = r_tag[MUL_LAT-1];
  assign o_prod  = r_prod[MUL_LAT-1];

endmodule
`default_nettype wire

// File: rtl/sid_mdac_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sid_mdac_sched : shares one multiplier across the voice MDAC products and
// the master-volume stage. Option macro: SID_VOLUME_EN            | rev 1.0
// ---------------------------------------------------------------------------
module sid_mdac_sched
  import sid_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CLKen,
  input  logic [11:0] VOICE0,
  input  logic [11:0] VOICE1,
  input  logic [11:0] VOICE2,
  input  logic [7:0]  ENV0,
  input  logic [7:0]  ENV1,
  input  logic [7:0]  ENV2,
  input  logic [15:0] MIX_IN,
  input  logic [3:0]  VOLUME,
  output logic [15:0] AMP0,
  output logic [15:0] AMP1,
  output logic [15:0] AMP2,
  output logic [15:0] OUT,
  output logic        VALID,
  output logic        BUSY,
  output logic        OVERRUN
);

  localparam int               NSLOT     = SID_NSLOT;
  localparam logic [TAG_W-1:0] LAST_SLOT = TAG_W'(NSLOT - 1);

  logic [1:0]       r_state;
  logic [TAG_W-1:0] r_slot;
  logic [11:0]      r_voice  [3];
  logic [7:0]       r_env    [3];
  logic [15:0]      r_mix;
  logic [15:0]      r_sh_amp [3];
  logic [15:0]      r_amp    [3];
  logic [15:0]      r_out;
  logic             r_valid;
  logic             r_overrun;

  logic               w_start;
  logic               w_issue;
  logic [MUL_A_W-1:0] w_mul_a;
  logic [MUL_B_W-1:0] w_mul_b;
  logic [MUL_B_W-1:0] w_vol_b;
  logic               w_res_vld;
  logic [TAG_W-1:0]   w_res_tag;
  logic [MUL_P_W-1:0] w_res_prod;
  logic [15:0]        w_res;
  logic               w_last_out;
  logic [15:0]        w_amp_nxt [3];
  logic [15:0]        w_out_nxt;
  logic               w_unused_lsb;

  assign w_start      = (r_state == ST_IDLE) && CLKen;
  assign w_issue      = (r_state == ST_ISSUE);
  assign w_res        = w_res_prod[MUL_P_W-1:8];
  assign w_unused_lsb = ^w_res_prod[7:0];
  assign w_last_out   = w_res_vld && (w_res_tag == LAST_SLOT);

  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_slot)
      SLOT_V0: begin w_mul_a = voice_to_a(r_voice[0]); w_mul_b = r_env[0]; end
      SLOT_V1: begin w_mul_a = voice_to_a(r_voice[1]); w_mul_b = r_env[1]; end
      SLOT_V2: begin w_mul_a = voice_to_a(r_voice[2]); w_mul_b = r_env[2]; end
      default: begin w_mul_a = r_mix;                  w_mul_b = w_vol_b;  end
    endcase
  end

  sid_shared_mul #(
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk     (CLK),
    .rst     (RST),
    .i_valid (w_issue),
    .i_tag   (r_slot),
    .i_a     (w_mul_a),
    .i_b     (w_mul_b),
    .o_valid (w_res_vld),
    .o_tag   (w_res_tag),
    .o_prod  (w_res_prod)
  );

  // The final product is forwarded straight into the output copy so every
  // result updates on the same edge that raises VALID.
  for (genvar k = 0; k < 3; k++) begin : g_amp
    assign w_amp_nxt[k] = (w_res_vld && (w_res_tag == TAG_W'(k))) ? w_res : r_sh_amp[k];
  end

`ifdef SID_VOLUME_EN
  logic [3:0]  r_vol;
  logic [15:0] r_sh_vol;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vol    <= '0;
      r_sh_vol <= '0;
    end else begin
      if (w_start) r_vol <= VOLUME;
      if (w_res_vld && (w_res_tag == SLOT_VOL)) r_sh_vol <= w_res;
    end
  end

  assign w_vol_b   = {r_vol, 4'b0000};
  assign w_out_nxt = (w_res_vld && (w_res_tag == SLOT_VOL)) ? w_res : r_sh_vol;
`else
  logic w_unused_vol;

  assign w_vol_b      = '0;
  assign w_out_nxt    = r_mix;
  assign w_unused_vol = ^VOLUME;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_slot    <= '0;
      r_mix     <= '0;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        r_voice[k]  <= '0;
        r_env[k]    <= '0;
        r_sh_amp[k] <= '0;
        r_amp[k]    <= '0;
      end
    end else begin
      r_valid   <= 1'b0;
      r_overrun <= CLKen && (r_state != ST_IDLE);
      if (w_res_vld) begin
        for (int k = 0; k < 3; k++) r_sh_amp[k] <= w_amp_nxt[k];
      end
      case (r_state)
        ST_IDLE: begin
          if (CLKen) begin
            r_voice[0] <= VOICE0;
            r_voice[1] <= VOICE1;
            r_voice[2] <= VOICE2;
            r_env[0]   <= ENV0;
            r_env[1]   <= ENV1;
            r_env[2]   <= ENV2;
            r_mix      <= MIX_IN;
            r_slot     <= SLOT_V0;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_slot <= r_slot + 1'b1;
          if (r_slot == LAST_SLOT) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_last_out) begin
            for (int k = 0; k < 3; k++) r_amp[k] <= w_amp_nxt[k];
            r_out   <= w_out_nxt;
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign AMP0    = r_amp[0];
  assign AMP1    = r_amp[1];
  assign AMP2    = r_amp[2];
  assign OUT     = r_out;
  assign VALID   = r_valid;
  assign BUSY    = (r_state != ST_IDLE);
  assign OVERRUN = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sid_mdac_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sid_mdac_sched : directed vector bench for sid_mdac_sched (either build
// of SID_VOLUME_EN).                                               | rev 1.0
// ---------------------------------------------------------------------------
module tb_sid_mdac_sched;

  typedef struct {
    logic [11:0] v0, v1, v2;
    logic [7:0]  e0, e1, e2;
    logic [15:0] mix;
    logic [3:0]  vol;
    int          a0, a1, a2, ov;
  } vec_t;

`ifdef SID_VOLUME_EN
  localparam int EXP_LAT = 7;
`else
  localparam int EXP_LAT = 6;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CLKen = 1'b0;
  logic [11:0] VOICE0 = '0, VOICE1 = '0, VOICE2 = '0;
  logic [7:0]  ENV0 = '0, ENV1 = '0, ENV2 = '0;
  logic [15:0] MIX_IN = '0;
  logic [3:0]  VOLUME = '0;
  logic [15:0] AMP0, AMP1, AMP2, OUT;
  logic        VALID, BUSY, OVERRUN;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  sid_mdac_sched #(.MUL_LAT(2)) dut (
    .CLK(CLK), .RST(RST), .CLKen(CLKen),
    .VOICE0(VOICE0), .VOICE1(VOICE1), .VOICE2(VOICE2),
    .ENV0(ENV0), .ENV1(ENV1), .ENV2(ENV2),
    .MIX_IN(MIX_IN), .VOLUME(VOLUME),
    .AMP0(AMP0), .AMP1(AMP1), .AMP2(AMP2), .OUT(OUT),
    .VALID(VALID), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_ops(input vec_t v);
    VOICE0 = v.v0; VOICE1 = v.v1; VOICE2 = v.v2;
    ENV0 = v.e0; ENV1 = v.e1; ENV2 = v.e2;
    MIX_IN = v.mix; VOLUME = v.vol;
  endtask

  // Raise CLKen for one cycle and count negedges until VALID (-1 on timeout).
  task automatic pulse_and_wait(output int lat, output int ovr);
    lat = -1;
    ovr = 0;
    CLKen = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      CLKen = 1'b0;
      if (OVERRUN) ovr++;
      if (VALID) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input vec_t v, input int lat);
    int exp_out;
`ifdef SID_VOLUME_EN
    exp_out = v.ov;
`else
    exp_out = int'($signed(v.mix));
`endif
    check({tag, ".latency"}, lat, EXP_LAT);
    check({tag, ".amp0"}, $signed(AMP0), v.a0);
    check({tag, ".amp1"}, $signed(AMP1), v.a1);
    check({tag, ".amp2"}, $signed(AMP2), v.a2);
    check({tag, ".out"},  $signed(OUT),  exp_out);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t  vecs [5];
    int    lat, ovr, nv, ovr_at;
    string nm;

    vecs[0] = '{12'h7FF, 12'h800, 12'h000, 8'd255, 8'd128, 8'd255, 16'd16000, 4'd8,
                32624, -16384, 0, 8000};
    vecs[1] = '{12'h001, 12'hFFF, 12'h400, 8'd1, 8'd1, 8'd100, 16'hC180, 4'd15,
                0, -1, 6400, -15000};
    vecs[2] = '{12'h800, 12'h7FF, 12'h123, 8'd255, 8'd0, 8'd7, 16'h3039, 4'd0,
                -32640, 0, 127, 0};
    vecs[3] = '{12'h100, 12'hF00, 12'h7FF, 8'd128, 8'd200, 8'd1, 16'hFFFF, 4'd15,
                2048, -3200, 127, -1};
    vecs[4] = '{12'hFFF, 12'h001, 12'h800, 8'd255, 8'd255, 8'd1, 16'h8000, 4'd15,
                -16, 15, -128, -30720};

    // Reset held with CLKen toggling: reset must dominate.
    apply_ops(vecs[0]);
    RST = 1'b1;
    CLKen = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("reset.valid", VALID, 0);
      check("reset.overrun", OVERRUN, 0);
      check("reset.busy", BUSY, 0);
      CLKen = ~CLKen;
    end
    RST = 1'b0;
    CLKen = 1'b0;
    @(negedge CLK);
    check("reset.amp0", AMP0, 0);
    check("reset.amp1", AMP1, 0);
    check("reset.amp2", AMP2, 0);
    check("reset.out", OUT, 0);
    check("reset.idle_valid", VALID, 0);

    for (int i = 0; i < 5; i++) begin
      nm = $sformatf("vec%0d", i);
      apply_ops(vecs[i]);
      pulse_and_wait(lat, ovr);
      check_frame(nm, vecs[i], lat);
      check({nm, ".busy_at_valid"}, BUSY, 1);
      check({nm, ".overrun"}, ovr, 0);
      @(negedge CLK);
      check({nm, ".valid_one_cycle"}, VALID, 0);
      check({nm, ".busy_after"}, BUSY, 0);
    end

    // CLKen during DONE is an overrun; CLKen in the following IDLE cycle starts.
    apply_ops(vecs[2]);
    pulse_and_wait(lat, ovr);
    check_frame("done_a", vecs[2], lat);
    apply_ops(vecs[3]);
    CLKen = 1'b1;
    @(negedge CLK);
    check("done.overrun", OVERRUN, 1);
    check("done.busy_idle", BUSY, 0);
    pulse_and_wait(lat, ovr);
    check_frame("done_b", vecs[3], lat);
    check("done_b.overrun", ovr, 0);
    @(negedge CLK);

    // Second CLKen three cycles into a frame, with new operands presented.
    apply_ops(vecs[0]);
    CLKen = 1'b1;
    lat = -1; nv = 0; ovr = 0; ovr_at = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      CLKen = (c == 3);
      if (c == 3) apply_ops(vecs[1]);
      if (OVERRUN) begin ovr++; ovr_at = c; end
      if (VALID) begin nv++; if (lat < 0) lat = c; end
    end
    check("ovr.pulses", ovr, 1);
    check("ovr.pulse_cycle", ovr_at, 4);
    check("ovr.valid_count", nv, 1);
    check_frame("ovr", vecs[0], lat);

    // Reset in the middle of ISSUE.
    apply_ops(vecs[1]);
    CLKen = 1'b1;
    @(negedge CLK);
    CLKen = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("mrst.amp0", AMP0, 0);
    check("mrst.amp1", AMP1, 0);
    check("mrst.amp2", AMP2, 0);
    check("mrst.out", OUT, 0);
    check("mrst.busy", BUSY, 0);
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (VALID) nv++;
    end
    check("mrst.valid_count", nv, 0);
    apply_ops(vecs[0]);
    pulse_and_wait(lat, ovr);
    check_frame("post_rst", vecs[0], lat);
    @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
